// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetch unit |
// | Revision  : 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] ir;
  } fetch_entry_t;

  localparam fetch_entry_t RESET_ENTRY = '{pc: 32'h0, nextpc: 32'h0, ir: NOP_INSTR};

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : power-of-two instruction FIFO with synchronous flush      |
// | Revision   : 1.0                                                       |
// +----------------------------------------------------------------------+
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  input  logic                   clear,
  output T                       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   c_depth = (PW+1)'(DEPTH);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == c_depth);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : RV32I fetch stage - PC, IMEM request/credit, redirect     |
// | Revision   : 1.0                                                       |
// +----------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          IMEM_AW   = 14
) (
  input  logic               CLK,
  input  logic               RST_N,
  output logic               IMEM_RDEN,
  output logic [IMEM_AW-1:0] IMEM_ADDR,
  input  logic [31:0]        IMEM_DOUT,
  input  logic               REDIRECT,
  input  logic [31:0]        REDIRECT_PC,
  output logic               FD_VALID,
  input  logic               FD_READY,
  output logic [31:0]        FD_PC,
  output logic [31:0]        FD_NEXTPC,
  output logic [31:0]        FD_IR
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] c_depth = (CW+1)'(DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_tag;
  logic          r_inflight;
  fetch_entry_t  r_hold;

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_fd;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_credit;
  logic          w_unused;

  assign FD_VALID = ~w_empty;
  assign w_pop    = FD_VALID & FD_READY;

  // Slots already spoken for: buffered entries plus the response still in flight.
  assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_issue  = RST_N & ~REDIRECT & (w_credit < c_depth);

  assign IMEM_RDEN = w_issue;
  assign IMEM_ADDR = r_pc[IMEM_AW+1:2];

  assign w_push       = r_inflight & ~REDIRECT;
  assign w_push_entry = '{pc: r_tag, nextpc: r_tag + 32'd4, ir: IMEM_DOUT};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc       <= RESET_VEC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (REDIRECT) begin
        r_pc <= {REDIRECT_PC[31:2], 2'b00};
      end else if (w_issue) begin
        r_tag <= r_pc;
        r_pc  <= r_pc + 32'd4;
      end
    end
  end

  // Keeps the last presented entry so FD_* stay stable while the FIFO is empty.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        r_hold <= RESET_ENTRY;
    else if (!w_empty) r_hold <= w_head;
  end

  assign w_fd      = w_empty ? r_hold : w_head;
  assign FD_PC     = w_fd.pc;
  assign FD_NEXTPC = w_fd.nextpc;
  assign FD_IR     = w_fd.ir;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .clear     (REDIRECT),
    .head      (w_head),
    .count     (w_count),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign w_unused = &{1'b0, w_full, REDIRECT_PC[1:0]};

endmodule
`default_nettype wire
